id_ex_issue_stage: RTL
======================

Name: id_ex_issue_stage

Overview:
- Decode/issue stage that feeds the execute-stage ALU (funct, operands, shift amount, 2-bit ALU op class) through a registered ID/EX pipeline boundary.
- Decodes the MIPS opcode into ALUOp1/ALUOp2 and the memory/writeback controls.
- Detects load-use hazards and inserts one bubble per hazard.
- Honours downstream backpressure (ex_ready) and flush. One instruction per cycle when unobstructed.

Parameters:
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- instr_in  in  32  fetched instruction
- instr_valid  in  1  instr_in valid this cycle
- in_ready  out  1  instruction consumed this cycle (combinational)
- rs_data  in  32  register file read port A
- rt_data  in  32  register file read port B
- flush  in  1  kill the current ID instruction and the ID/EX contents
- ex_ready  in  1  execute stage can accept the ID/EX contents
- ex_valid  out  1  ID/EX register holds a real instruction
- ex_funct  out  6  instr[5:0] for ALU control
- ex_sa  out  5  instr[10:6]
- ex_data1  out  32  rs_data
- ex_data2  out  32  rt_data, or sign-extended imm when alu_src=1
- ex_aluop1  out  1  ALUOp MSB
- ex_aluop2  out  1  ALUOp LSB
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  downstream controls
- ex_dest  out  5  destination register (rd for R-type, rt otherwise)
- ex_rt  out  5  instr[20:16], used for hazard compare
- id_stall  out  1  load-use bubble inserted this cycle (combinational)
- illegal_op  out  1  one-cycle pulse, registered, when an unsupported opcode is consumed
- stall_count  out  STALL_CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (synchronous, priority over everything): all registered outputs are 0, stall_count = 0, FSM = RUN.
- Decode, with {ALUOp1,ALUOp2}:
  - R-type 0x00: 10, reg_write, dest = rd, alu_src = 0.
  - lw 0x23: 00, mem_read, mem_to_reg, reg_write, alu_src = 1.
  - sw 0x2B: 00, mem_write, alu_src = 1.
  - beq 0x04: 01, no writes, alu_src = 0.
  - addi 0x08: 00, reg_write, alu_src = 1.
  - Any other opcode: consumed, loaded as a bubble (ex_valid = 0), illegal_op = 1 the next cycle.
- Immediate is sign-extended from instr[15:0] to 32 bits.
- Hazard (combinational) = ex_valid & ex_mem_read & ex_rt != 0 & (ex_rt == rs | (ex_rt == rt & opcode in {R-type, sw, beq})).
- Advance condition adv = ~ex_valid | ex_ready.
- Priority per cycle: reset > flush > hold > hazard > issue.
  - flush: ex_valid <= 0, in_ready = 1 when instr_valid (instruction discarded), FSM <= RUN, no stall count.
  - hold (~adv): all ID/EX outputs hold, in_ready = 0, id_stall = 0.
  - hazard (adv & instr_valid & hazard): ex_valid <= 0, in_ready = 0, id_stall = 1, FSM <= LU_STALL, stall_count += 1 (saturates at all-ones).
  - issue (adv & instr_valid): load the ID/EX register, ex_valid <= legal opcode, in_ready = 1, FSM <= RUN.
  - adv & ~instr_valid: ex_valid <= 0.
- FSM:
  - RUN: normal operation.
  - LU_STALL: lasts exactly one cycle. The hazard check is suppressed; the bubble guarantees the load has left EX. Returns to RUN on the next advance.
- Latency: an instruction consumed in cycle N is visible on the ex_* outputs in cycle N+1.
- Reset asserted mid-stall: next cycle FSM = RUN, ex_valid = 0, stall_count = 0.

Test Plan:
- Plain issue: reset, then issue add $3,$1,$2 (0x00221820) with rs_data = 5, rt_data = 7, ex_ready = 1. Next cycle: ex_valid = 1, aluop = 10, funct = 0x20, data1 = 5, data2 = 7, dest = 3, reg_write = 1.
- Load-use: issue lw $2,4($1) (0x8C220004) then add $3,$2,$2. Second cycle: id_stall = 1, in_ready = 0, ex_valid = 0 the following cycle. The add issues one cycle later; stall_count = 1. Destination $0 instead of $2: no stall.
- Backpressure: ex_valid = 1, ex_ready held 0 for 3 cycles with a new instruction waiting. ex_* outputs stay stable and in_ready = 0. The new instruction issues on the cycle after ex_ready returns to 1.
- Immediate: addi $4,$1,-1 (0x2024FFFF). ex_data2 = 0xFFFFFFFF, aluop = 00, dest = 4. beq gives aluop = 01 with reg_write = 0.
- Flush/illegal: flush with a valid instruction gives ex_valid = 0 next cycle and in_ready = 1. Opcode 0x3F gives illegal_op = 1 for one cycle and ex_valid = 0.
- Reset mid-stall: assert reset during the LU_STALL cycle. Next cycle all outputs = 0 and stall_count = 0.

Source files
------------

// File: rtl/id_ex_issue_stage_if.sv
// id_ex_issue_stage_if: fetch-side handshake, operand inputs and ID/EX outputs of the issue stage
interface id_ex_issue_stage_if #(parameter int STALL_CNT_W = 16);
    logic [31:0]            instr_in;
    logic                   instr_valid;
    logic                   in_ready;
    logic [31:0]            rs_data;
    logic [31:0]            rt_data;
    logic                   flush;
    logic                   ex_ready;
    logic                   ex_valid;
    logic [5:0]             ex_funct;
    logic [4:0]             ex_sa;
    logic [31:0]            ex_data1;
    logic [31:0]            ex_data2;
    logic                   ex_aluop1;
    logic                   ex_aluop2;
    logic                   ex_reg_write;
    logic                   ex_mem_read;
    logic                   ex_mem_write;
    logic                   ex_mem_to_reg;
    logic [4:0]             ex_dest;
    logic [4:0]             ex_rt;
    logic                   id_stall;
    logic                   illegal_op;
    logic [STALL_CNT_W-1:0] stall_count;

    modport slave (
        input  instr_in, instr_valid, rs_data, rt_data, flush, ex_ready,
        output in_ready, ex_valid, ex_funct, ex_sa, ex_data1, ex_data2, ex_aluop1, ex_aluop2,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_dest, ex_rt,
               id_stall, illegal_op, stall_count
    );
    modport master (
        output instr_in, instr_valid, rs_data, rt_data, flush, ex_ready,
        input  in_ready, ex_valid, ex_funct, ex_sa, ex_data1, ex_data2, ex_aluop1, ex_aluop2,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_dest, ex_rt,
               id_stall, illegal_op, stall_count
    );
endinterface

// File: rtl/id_ex_issue_stage.sv
// id_ex_issue_stage: MIPS decode/issue into a registered ID/EX boundary with load-use bubbles
module id_ex_issue_stage #(parameter int STALL_CNT_W = 16) (
    input logic clk,
    input logic reset,
    id_ex_issue_stage_if.slave bus
);
    typedef enum logic {RUN, LU_STALL} state_t;
    typedef struct packed {
        logic        valid;
        logic [5:0]  funct;
        logic [4:0]  sa;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  aluop;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [4:0]  dest;
        logic [4:0]  rt;
    } idex_t;

    state_t                 state_q, state_d;
    idex_t                  ex_q, ex_d, iss;
    logic                   ill_q, ill_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]            ins;
    logic [5:0]             op;
    logic                   is_r, is_lw, is_sw, is_beq, is_addi, legal, alu_src, haz, adv;
    logic                   in_ready, id_stall;

    assign ins     = bus.instr_in;
    assign op      = ins[31:26];
    assign is_r    = op == 6'h00;
    assign is_lw   = op == 6'h23;
    assign is_sw   = op == 6'h2B;
    assign is_beq  = op == 6'h04;
    assign is_addi = op == 6'h08;
    assign legal   = is_r | is_lw | is_sw | is_beq | is_addi;
    assign alu_src = is_lw | is_sw | is_addi;
    assign adv     = ~ex_q.valid | bus.ex_ready;
    // LU_STALL suppresses the compare: the bubble already pushed the load out of EX
    assign haz = state_q == RUN & ex_q.valid & ex_q.mr & ex_q.rt != 5'd0 &
                 (ex_q.rt == ins[25:21] | (ex_q.rt == ins[20:16] & (is_r | is_sw | is_beq)));

    always_comb begin
        iss.valid = legal;
        iss.funct = ins[5:0];
        iss.sa    = ins[10:6];
        iss.d1    = bus.rs_data;
        iss.d2    = alu_src ? {{16{ins[15]}}, ins[15:0]} : bus.rt_data;
        iss.aluop = is_r ? 2'b10 : is_beq ? 2'b01 : 2'b00;
        iss.rw    = is_r | is_lw | is_addi;
        iss.mr    = is_lw;
        iss.mw    = is_sw;
        iss.m2r   = is_lw;
        iss.dest  = is_r ? ins[15:11] : ins[20:16];
        iss.rt    = ins[20:16];
    end

    always_comb begin
        state_d  = state_q;
        ex_d     = ex_q;
        ill_d    = 1'b0;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        id_stall = 1'b0;
        if (bus.flush) begin
            ex_d.valid = 1'b0;
            state_d    = RUN;
            in_ready   = bus.instr_valid;
        end else if (!adv) begin
            state_d = state_q;
        end else if (bus.instr_valid && haz) begin
            ex_d.valid = 1'b0;
            id_stall   = 1'b1;
            state_d    = LU_STALL;
            cnt_d      = cnt_q + {{(STALL_CNT_W-1){1'b0}}, ~&cnt_q};
        end else if (bus.instr_valid) begin
            ex_d     = iss;
            in_ready = 1'b1;
            ill_d    = ~legal;
            state_d  = RUN;
        end else begin
            ex_d.valid = 1'b0;
            state_d    = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            ex_q    <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.id_stall      = id_stall;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_funct      = ex_q.funct;
    assign bus.ex_sa         = ex_q.sa;
    assign bus.ex_data1      = ex_q.d1;
    assign bus.ex_data2      = ex_q.d2;
    assign bus.ex_aluop1     = ex_q.aluop[1];
    assign bus.ex_aluop2     = ex_q.aluop[0];
    assign bus.ex_reg_write  = ex_q.rw;
    assign bus.ex_mem_read   = ex_q.mr;
    assign bus.ex_mem_write  = ex_q.mw;
    assign bus.ex_mem_to_reg = ex_q.m2r;
    assign bus.ex_dest       = ex_q.dest;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.illegal_op    = ill_q;
    assign bus.stall_count   = cnt_q;
endmodule
